// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, slice-count helper and
// the add/subtract opcode values also used by the ALU opcode decoder.
package alu_pkg;

    // Sequencer states of the multi-cycle add/subtract unit.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Operation select values on the sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of slice cycles needed for one full-width operation.
    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Purely combinational SLICE-bit carry-lookahead adder.
// Ports:
//   a, b   in  SLICE : operand bits
//   cin    in  1     : carry into bit 0
//   sum    out SLICE : a + b + cin (low SLICE bits)
//   cout   out 1     : carry out of bit SLICE-1
//   c_msb  out 1     : carry into bit SLICE-1 (for signed overflow)
module cla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE-1:0] prop_s;
    logic [SLICE-1:0] gen_s;
    logic [SLICE:0]   carry_s;

    assign prop_s = a ^ b;
    assign gen_s  = a & b;

    // Full lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, each
    // term built from a running AND of the propagates above bit j.
    always_comb begin : carry_lookahead
        logic acc_v;
        logic prod_v;
        carry_s    = {(SLICE+1){1'b0}};
        carry_s[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            acc_v  = gen_s[i];
            prod_v = prop_s[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc_v  = acc_v | (prod_v & gen_s[j]);
                prod_v = prod_v & prop_s[j];
            end
            carry_s[i+1] = acc_v | (prod_v & cin);
        end
    end

    assign sum   = prop_s ^ carry_s[SLICE-1:0];
    assign cout  = carry_s[SLICE];
    assign c_msb = carry_s[SLICE-1];

endmodule

// File: rtl/cla_addsub_seq.sv
// Multi-cycle add/subtract unit: resolves one SLICE-bit CLA slice per clock,
// chaining the carry through a register, and reports carry/overflow/zero.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, sub, a, b, cin : request and operands, captured in IDLE/DONE
//   busy                : high while slices are being computed
//   done                : one-cycle pulse when result becomes valid
//   result, cout, overflow, zero : registered result and flags, held
//                         until the next accepted start
module cla_addsub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_param_check
        $error("cla_addsub_seq: WIDTH must be a positive multiple of SLICE");
    end

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             overflow_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;

    logic [SLICE-1:0]       slice_sum_s;
    logic                   slice_cout_s;
    logic                   slice_cmsb_s;
    logic [WIDTH+SLICE-1:0] shift_cat_s;
    logic [WIDTH-1:0]       result_next_s;

    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a     (a_r[SLICE-1:0]),
        .b     (b_r[SLICE-1:0]),
        .cin   (carry_r),
        .sum   (slice_sum_s),
        .cout  (slice_cout_s),
        .c_msb (slice_cmsb_s)
    );

    // New slice enters at the MSB end; the concatenation keeps this legal
    // even when the whole word is a single slice.
    assign shift_cat_s   = {slice_sum_s, result_r} >> SLICE;
    assign result_next_s = shift_cat_s[WIDTH-1:0];

    // Sequencer, operand shift registers, carry chain and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Subtract is a + ~b + ~borrow_in.
                        a_r        <= a;
                        b_r        <= (sub == OP_SUB) ? ~b : b;
                        carry_r    <= (sub == OP_SUB) ? ~cin : cin;
                        cnt_r      <= {CNT_W{1'b0}};
                        result_r   <= {WIDTH{1'b0}};
                        cout_r     <= 1'b0;
                        overflow_r <= 1'b0;
                        zero_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    result_r <= result_next_s;
                    a_r      <= a_r >> SLICE;
                    b_r      <= b_r >> SLICE;
                    carry_r  <= slice_cout_s;
                    if (cnt_r == CNT_LAST) begin
                        cout_r     <= slice_cout_s;
                        overflow_r <= slice_cout_s ^ slice_cmsb_s;
                        zero_r     <= (result_next_s == {WIDTH{1'b0}});
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        state_r    <= DONE;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign cout     = cout_r;
    assign overflow = overflow_r;
    assign zero     = zero_r;

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Directed, table-driven bench for cla_addsub_seq (WIDTH=16, SLICE=4),
// plus hand-written handshake, back-to-back and mid-run reset sequences.
module tb_cla_addsub_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic        cin   = 1'b0;
    logic [15:0] a     = 16'h0000;
    logic [15:0] b     = 16'h0000;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        overflow;
    logic        zero;

    int n_applied = 0;
    int n_miss    = 0;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    cla_addsub_seq #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive a request at the falling edge; return just after the accept edge.
    task automatic start_op(input logic s, input logic [15:0] x, input logic [15:0] y,
                            input logic ci);
        @(negedge clk);
        sub   = s;
        a     = x;
        b     = y;
        cin   = ci;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done, bounded; also count busy-high samples on the way.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy === 1'b1) busy_cnt++;
        end while ((done !== 1'b1) && (cycles < 20));
    endtask

    initial begin
        int cyc;
        int bc;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};

        // Power-on reset.
        #1 rst_n = 1'b0;
        #16;
        check("reset_outputs", {busy, done, result, cout, overflow, zero}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("v%0d_accept_busy", i), {31'h0, busy}, 32'h1);
            check($sformatf("v%0d_accept_clear", i), {done, result, cout, overflow, zero}, 32'h0);
            wait_done(cyc, bc);
            check($sformatf("v%0d_latency", i), cyc, 32'd4);
            check($sformatf("v%0d_busy_cycles", i), bc, 32'd3);
            check($sformatf("v%0d_busy_at_done", i), {31'h0, busy}, 32'h0);
            check($sformatf("v%0d_result", i), {16'h0, result}, {16'h0, vecs[i].res});
            check($sformatf("v%0d_flags", i), {29'h0, cout, overflow, zero},
                  {29'h0, vecs[i].cout, vecs[i].ovf, vecs[i].zero});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), {31'h0, done}, 32'h0);
            check($sformatf("v%0d_hold", i), {13'h0, result, cout, overflow, zero},
                  {13'h0, vecs[i].res, vecs[i].cout, vecs[i].ovf, vecs[i].zero});
        end

        // start pulsed during RUN with different operands is ignored.
        start_op(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        @(negedge clk);
        sub   = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        check("run_start_result", {16'h0, result}, 32'h2233);
        check("run_start_flags", {29'h0, cout, overflow, zero}, 32'h0);
        @(posedge clk);
        #1;
        check("run_start_idle", {30'h0, busy, done}, 32'h0);

        // Back-to-back: start held in the DONE cycle.
        start_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        wait_done(cyc, bc);
        check("b2b_first_result", {16'h0, result}, 32'h8000);
        start_op(1'b1, 16'h0005, 16'h0007, 1'b0);
        check("b2b_accept", {14'h0, busy, done, result}, {14'h0, 1'b1, 1'b0, 16'h0000});
        wait_done(cyc, bc);
        check("b2b_latency", cyc, 32'd4);
        check("b2b_second_result", {13'h0, result, cout, overflow, zero},
              {13'h0, 16'hFFFE, 1'b0, 1'b0, 1'b0});

        // Reset two cycles into a run clears everything asynchronously.
        start_op(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset", {busy, done, result, cout, overflow, zero}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(1'b0, 16'h0001, 16'h0001, 1'b0);
        wait_done(cyc, bc);
        check("post_reset_latency", cyc, 32'd4);
        check("post_reset_result", {13'h0, result, cout, overflow, zero},
              {13'h0, 16'h0002, 1'b0, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
